// File: rtl/register_file_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Mode constants name the BYPASS/ZERO_REG settings; the functions size and slice the flat port vectors.
package register_file_sb_pkg;

    localparam int BYPASS_OFF   = 0;
    localparam int BYPASS_ON    = 1;
    localparam int ZERO_REG_OFF = 0;
    localparam int ZERO_REG_ON  = 1;

    // Ceiling log2, never below 1 so single-entry fields still get a bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Decode-stage port bundle of the register file: read ports, write port, scoreboard set and count.
// regWrite and pend_set are single-cycle qualifiers sampled on the rising clock edge; there is no backpressure.
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
);
    localparam int ADDR_W = clog2(NUM_REGS);
    localparam int BE_W   = DATA_W / 8;
    localparam int CNT_W  = clog2(NUM_REGS + 1);

    logic [NUM_RD*ADDR_W-1:0] read_reg;
    logic [NUM_RD*DATA_W-1:0] read_data;
    logic [NUM_RD-1:0]        read_busy;
    logic                     regWrite;
    logic [ADDR_W-1:0]        write_reg;
    logic [DATA_W-1:0]        write_data;
    logic [BE_W-1:0]          write_be;
    logic                     pend_set;
    logic [ADDR_W-1:0]        pend_reg;
    logic [CNT_W-1:0]         pend_cnt;

    modport master (
        output read_reg, regWrite, write_reg, write_data, write_be, pend_set, pend_reg,
        input  read_data, read_busy, pend_cnt
    );

    modport slave (
        input  read_reg, regWrite, write_reg, write_data, write_be, pend_set, pend_reg,
        output read_data, read_busy, pend_cnt
    );

endinterface

// File: rtl/register_file_sb_rf_read_port.sv
// One combinational read port: address mux, optional same-cycle write merge, load-pending busy flag.
module rf_read_port
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = ZERO_REG_ON,
    parameter int BYPASS   = BYPASS_ON,
    parameter int ADDR_W   = clog2(NUM_REGS),
    parameter int BE_W     = DATA_W / 8
) (
    input  logic [ADDR_W-1:0]          rd_addr_i,
    input  logic [NUM_REGS*DATA_W-1:0] regs_i,
    input  logic [NUM_REGS-1:0]        pending_i,
    input  logic                       wr_valid_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic [BE_W-1:0]            wr_be_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       rd_busy_o
);

    logic [DATA_W-1:0] stored;
    logic              busy_raw;
    logic              hit;

    // Out-of-range addresses match no entry and therefore read as zero, not busy.
    always_comb begin
        stored   = '0;
        busy_raw = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rd_addr_i == ADDR_W'(r)) begin
                stored   = regs_i[r*DATA_W +: DATA_W];
                busy_raw = pending_i[r];
            end
        end
        if (ZERO_REG == 1 && rd_addr_i == '0) begin
            stored   = '0;
            busy_raw = 1'b0;
        end
    end

    // wr_valid_i already excludes non-writable targets, so reg 0 never bypasses.
    always_comb begin
        hit       = (BYPASS == 1) && wr_valid_i && (wr_addr_i == rd_addr_i);
        rd_data_o = stored;
        if (hit) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be_i[b]) rd_data_o[b*8 +: 8] = wr_data_i[b*8 +: 8];
            end
        end
        rd_busy_o = busy_raw && !hit;
    end

endmodule

// File: rtl/register_file_sb.sv
// Parametrised multi-port register file with byte-enabled writes, optional bypass
// and a per-register load-pending scoreboard feeding the hazard unit.
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = ZERO_REG_ON,
    parameter int BYPASS   = BYPASS_ON
) (
    input  logic               clk,
    input  logic               rst_n,
    register_file_sb_if.slave  bus
);

    localparam int ADDR_W = clog2(NUM_REGS);
    localparam int BE_W   = DATA_W / 8;
    localparam int CNT_W  = clog2(NUM_REGS + 1);

    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]        pending_q, pending_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       wr_ok, set_ok;
    logic                       set_was, clr_was, inc, dec;
    logic [NUM_RD*DATA_W-1:0]   rd_data_w;
    logic [NUM_RD-1:0]          rd_busy_w;

    assign wr_ok  = bus.regWrite
                 && ({1'b0, bus.write_reg} < (ADDR_W+1)'(NUM_REGS))
                 && !(ZERO_REG == 1 && bus.write_reg == '0);
    assign set_ok = bus.pend_set
                 && ({1'b0, bus.pend_reg} < (ADDR_W+1)'(NUM_REGS))
                 && !(ZERO_REG == 1 && bus.pend_reg == '0);

    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_ok && bus.write_reg == ADDR_W'(r)) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (bus.write_be[b]) regs_d[r*DATA_W + b*8 +: 8] = bus.write_data[b*8 +: 8];
                end
            end
        end
    end

    // A set and a clear on the same register resolve to set; the count tracks the old bits.
    always_comb begin
        pending_d = pending_q;
        set_was   = 1'b0;
        clr_was   = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (set_ok && bus.pend_reg == ADDR_W'(r)) set_was = pending_q[r];
            if (wr_ok && bus.write_reg == ADDR_W'(r)) clr_was = pending_q[r];
            pending_d[r] = (set_ok && bus.pend_reg == ADDR_W'(r))
                        || (pending_q[r] && !(wr_ok && bus.write_reg == ADDR_W'(r)));
        end
        inc   = set_ok && !set_was;
        dec   = wr_ok && clr_was && !(set_ok && bus.pend_reg == bus.write_reg);
        cnt_d = cnt_q + CNT_W'(inc) - CNT_W'(dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS),
            .ADDR_W   (ADDR_W),
            .BE_W     (BE_W)
        ) u_port (
            .rd_addr_i  (bus.read_reg[slice_lo(k, ADDR_W) +: ADDR_W]),
            .regs_i     (regs_q),
            .pending_i  (pending_q),
            .wr_valid_i (wr_ok),
            .wr_addr_i  (bus.write_reg),
            .wr_data_i  (bus.write_data),
            .wr_be_i    (bus.write_be),
            .rd_data_o  (rd_data_w[slice_lo(k, DATA_W) +: DATA_W]),
            .rd_busy_o  (rd_busy_w[k])
        );
    end

    // Gated so a bypassed write cannot leak onto the read bus during reset.
    assign bus.read_data = rst_n ? rd_data_w : '0;
    assign bus.read_busy = rst_n ? rd_busy_w : '0;
    assign bus.pend_cnt  = cnt_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: default 32x32 two-port instance plus a 16x64 three-port no-bypass instance.
module tb_register_file_sb;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    register_file_sb_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) rf1 ();
    register_file_sb_if #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(3)) rf2 ();

    register_file_sb #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf1.slave)
    );

    register_file_sb #(.DATA_W(64), .NUM_REGS(16), .NUM_RD(3), .ZERO_REG(1), .BYPASS(0)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle1();
        rf1.regWrite   = 1'b0;
        rf1.write_reg  = '0;
        rf1.write_data = '0;
        rf1.write_be   = '0;
        rf1.pend_set   = 1'b0;
        rf1.pend_reg   = '0;
    endtask

    task automatic write1(input logic [4:0] r, input logic [31:0] d, input logic [3:0] be);
        rf1.regWrite   = 1'b1;
        rf1.write_reg  = r;
        rf1.write_data = d;
        rf1.write_be   = be;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle1();
        rf1.read_reg = {5'd2, 5'd1};
        rf2.read_reg = '0;
        rf2.regWrite = 1'b0;
        rf2.write_reg = '0;
        rf2.write_data = '0;
        rf2.write_be = '0;
        rf2.pend_set = 1'b0;
        rf2.pend_reg = '0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (rf1.read_data !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected %h", rf1.read_data, 64'h0);
        end
        tests_run++;
        if (rf1.read_busy !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected %b", rf1.read_busy, 2'b00);
        end
        tests_run++;
        if (rf1.pend_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d expected 0", rf1.pend_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (rf1.read_data !== 64'h0) begin
            tests_failed++;
            $display("FAIL post_reset_data: got %h expected %h", rf1.read_data, 64'h0);
        end
    endtask

    task automatic test_byte_write();
        @(negedge clk);
        write1(5'd31, 32'h0000_3000, 4'hF);
        @(negedge clk);
        write1(5'd30, 32'hFFFF_FFFF, 4'b0011);
        @(negedge clk);
        idle1();
        rf1.read_reg = {5'd30, 5'd31};
        #1;
        tests_run++;
        if (rf1.read_data[31:0] !== 32'h0000_3000) begin
            tests_failed++;
            $display("FAIL full_write_r31: got %h expected %h", rf1.read_data[31:0], 32'h0000_3000);
        end
        tests_run++;
        if (rf1.read_data[63:32] !== 32'h0000_FFFF) begin
            tests_failed++;
            $display("FAIL low_bytes_r30: got %h expected %h", rf1.read_data[63:32], 32'h0000_FFFF);
        end
        // Upper-half write to r30: bypass merges new high bytes with stored low bytes.
        @(negedge clk);
        write1(5'd30, 32'h1234_5678, 4'b1100);
        #1;
        tests_run++;
        if (rf1.read_data[63:32] !== 32'h1234_FFFF) begin
            tests_failed++;
            $display("FAIL partial_bypass_r30: got %h expected %h", rf1.read_data[63:32], 32'h1234_FFFF);
        end
        @(negedge clk);
        write1(5'd30, 32'h0000_0000, 4'b0000);
        #1;
        tests_run++;
        if (rf1.read_data[63:32] !== 32'h1234_FFFF) begin
            tests_failed++;
            $display("FAIL be_zero_bypass: got %h expected %h", rf1.read_data[63:32], 32'h1234_FFFF);
        end
        @(negedge clk);
        idle1();
        #1;
        tests_run++;
        if (rf1.read_data[63:32] !== 32'h1234_FFFF) begin
            tests_failed++;
            $display("FAIL be_zero_hold: got %h expected %h", rf1.read_data[63:32], 32'h1234_FFFF);
        end
    endtask

    task automatic test_zero_reg_bypass();
        @(negedge clk);
        write1(5'd0, 32'hFFFF_FFFF, 4'hF);
        rf1.read_reg = {5'd5, 5'd0};
        #1;
        tests_run++;
        if (rf1.read_data[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL r0_no_bypass: got %h expected %h", rf1.read_data[31:0], 32'h0);
        end
        @(negedge clk);
        tests_run++;
        if (rf1.read_data[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL r0_after_write: got %h expected %h", rf1.read_data[31:0], 32'h0);
        end
        write1(5'd5, 32'hA5A5_A5A5, 4'hF);
        #1;
        tests_run++;
        if (rf1.read_data[63:32] !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("FAIL r5_bypass: got %h expected %h", rf1.read_data[63:32], 32'hA5A5_A5A5);
        end
        @(negedge clk);
        idle1();
        rf1.read_reg = {5'd5, 5'd5};
        #1;
        tests_run++;
        if (rf1.read_data !== {32'hA5A5_A5A5, 32'hA5A5_A5A5}) begin
            tests_failed++;
            $display("FAIL r5_both_ports: got %h expected %h", rf1.read_data, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        rf1.pend_set = 1'b1;
        rf1.pend_reg = 5'd7;
        rf1.read_reg = {5'd0, 5'd7};
        #1;
        tests_run++;
        if (rf1.read_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_before_edge: got %b expected 0", rf1.read_busy[0]);
        end
        @(negedge clk);
        rf1.pend_reg = 5'd0;
        #1;
        tests_run++;
        if (rf1.read_busy !== 2'b01) begin
            tests_failed++;
            $display("FAIL busy_r7: got %b expected %b", rf1.read_busy, 2'b01);
        end
        tests_run++;
        if (rf1.pend_cnt !== 6'd1) begin
            tests_failed++;
            $display("FAIL cnt_after_set: got %0d expected 1", rf1.pend_cnt);
        end
        @(negedge clk);
        tests_run++;
        if (rf1.pend_cnt !== 6'd1) begin
            tests_failed++;
            $display("FAIL cnt_r0_set_ignored: got %0d expected 1", rf1.pend_cnt);
        end
        rf1.pend_set = 1'b0;
        write1(5'd7, 32'h0000_0077, 4'hF);
        #1;
        tests_run++;
        if (rf1.read_busy[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_bypass_clear: got %b expected 0", rf1.read_busy[0]);
        end
        @(negedge clk);
        idle1();
        #1;
        tests_run++;
        if (rf1.pend_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL cnt_after_clear: got %0d expected 0", rf1.pend_cnt);
        end
        tests_run++;
        if (rf1.read_data[31:0] !== 32'h0000_0077) begin
            tests_failed++;
            $display("FAIL r7_loaded: got %h expected %h", rf1.read_data[31:0], 32'h0000_0077);
        end
    endtask

    task automatic test_set_clear_reset();
        @(negedge clk);
        rf1.pend_set = 1'b1;
        rf1.pend_reg = 5'd9;
        write1(5'd9, 32'h0000_0009, 4'hF);
        @(negedge clk);
        idle1();
        rf1.read_reg = {5'd10, 5'd9};
        #1;
        tests_run++;
        if (rf1.read_busy !== 2'b01) begin
            tests_failed++;
            $display("FAIL set_wins_busy: got %b expected %b", rf1.read_busy, 2'b01);
        end
        tests_run++;
        if (rf1.pend_cnt !== 6'd1) begin
            tests_failed++;
            $display("FAIL set_wins_cnt: got %0d expected 1", rf1.pend_cnt);
        end
        // Set r10 while clearing r9 on the same edge: count must not move.
        rf1.pend_set = 1'b1;
        rf1.pend_reg = 5'd10;
        write1(5'd9, 32'h0000_0099, 4'hF);
        @(negedge clk);
        idle1();
        #1;
        tests_run++;
        if (rf1.read_busy !== 2'b10) begin
            tests_failed++;
            $display("FAIL swap_busy: got %b expected %b", rf1.read_busy, 2'b10);
        end
        tests_run++;
        if (rf1.pend_cnt !== 6'd1) begin
            tests_failed++;
            $display("FAIL swap_cnt: got %0d expected 1", rf1.pend_cnt);
        end
        @(negedge clk);
        write1(5'd11, 32'hDEAD_BEEF, 4'hF);
        rf1.read_reg = {5'd11, 5'd10};
        #1;
        tests_run++;
        if (rf1.read_data[63:32] !== 32'hDEAD_BEEF || rf1.read_busy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_state: got %h/%b expected %h/1", rf1.read_data[63:32], rf1.read_busy[0], 32'hDEAD_BEEF);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (rf1.read_data !== 64'h0) begin
            tests_failed++;
            $display("FAIL async_reset_data: got %h expected %h", rf1.read_data, 64'h0);
        end
        tests_run++;
        if (rf1.read_busy !== 2'b00 || rf1.pend_cnt !== 6'd0) begin
            tests_failed++;
            $display("FAIL async_reset_sb: got %b/%0d expected 00/0", rf1.read_busy, rf1.pend_cnt);
        end
        @(negedge clk);
        idle1();
        rst_n = 1'b1;
        rf1.read_reg = {5'd31, 5'd11};
        #1;
        tests_run++;
        if (rf1.read_data !== 64'h0) begin
            tests_failed++;
            $display("FAIL write_dropped: got %h expected %h", rf1.read_data, 64'h0);
        end
    endtask

    task automatic test_wide_no_bypass();
        @(negedge clk);
        rf2.read_reg   = {4'd15, 4'd15, 4'd15};
        rf2.regWrite   = 1'b1;
        rf2.write_reg  = 4'd15;
        rf2.write_data = 64'h1111_1111_1111_1111;
        rf2.write_be   = 8'hFF;
        @(negedge clk);
        rf2.write_data = 64'h0123_4567_89AB_CDEF;
        #1;
        tests_run++;
        if (rf2.read_data !== {3{64'h1111_1111_1111_1111}}) begin
            tests_failed++;
            $display("FAIL wide_old_value: got %h expected %h", rf2.read_data, {3{64'h1111_1111_1111_1111}});
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (rf2.read_data !== {3{64'h0123_4567_89AB_CDEF}}) begin
            tests_failed++;
            $display("FAIL wide_new_value: got %h expected %h", rf2.read_data, {3{64'h0123_4567_89AB_CDEF}});
        end
        tests_run++;
        if (rf2.read_busy !== 3'b000 || rf2.pend_cnt !== 5'd0) begin
            tests_failed++;
            $display("FAIL wide_sb_idle: got %b/%0d expected 000/0", rf2.read_busy, rf2.pend_cnt);
        end
        @(negedge clk);
        rf2.regWrite = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_byte_write();
        test_zero_reg_bypass();
        test_scoreboard();
        test_set_clear_reset();
        test_wide_no_bypass();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the fixed 32x32 two-read/one-write MIPS register block.
- Adds configurable width, depth and read-port count, byte-enabled clocked writes, and optional write-to-read bypass.
- Adds a per-register load-pending scoreboard with per-read-port busy flags.
- Sits in the decode stage of the pipelined datapath. Feeds operand reads and supplies the hazard unit with stall information.

Parameters:
- DATA_W, 32: register width in bits; must be a multiple of 8. BE_W = DATA_W/8 (localparam).
- NUM_REGS, 32: number of registers, at least 2. ADDR_W = clog2(NUM_REGS) (localparam).
- NUM_RD, 2: number of independent read ports, at least 1.
- ZERO_REG, 1: 1 = register 0 always reads 0 and ignores writes and pend_set.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- read_reg  in  NUM_RD*ADDR_W  read addresses, port k in slice k
- read_data  out  NUM_RD*DATA_W  read data, port k in slice k
- read_busy  out  NUM_RD  port k operand has a pending load
- regWrite  in  1  write enable
- write_reg  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- write_be  in  BE_W  byte enables, bit i covers byte i
- pend_set  in  1  mark pend_reg as awaiting a load result
- pend_reg  in  ADDR_W  register to mark
- pend_cnt  out  clog2(NUM_REGS+1)  registered count of pending registers

Behaviour:
- Reset:
  - Asynchronous on rst_n low: all registers = 0, all pending bits = 0, pend_cnt = 0.
  - While in reset, read_data = 0 and read_busy = 0.
  - Reset mid-write drops that write.
- Write:
  - At posedge clk, when regWrite=1 and the target is writable, each byte i with write_be[i]=1 takes write_data byte i; other bytes hold.
  - Not writable: write_reg >= NUM_REGS, or write_reg==0 with ZERO_REG=1. These writes are ignored.
  - write_be = 0 with regWrite=1 changes no data but still clears pending.
- Read:
  - Combinational, zero latency.
  - Returns 0 when read_reg[k] >= NUM_REGS, or when read_reg[k]==0 with ZERO_REG=1.
  - If BYPASS=1, regWrite=1 and write_reg==read_reg[k] (writable): enabled bytes come from write_data, the rest from stored data.
  - If BYPASS=0, the stored (old) value is returned until the edge.
  - Multiple ports on the same address return identical data.
- Scoreboard:
  - At posedge, pend_set=1 sets pending[pend_reg]. Ignored for reg 0 when ZERO_REG=1, and for out-of-range addresses.
  - At posedge, a writable regWrite to register r clears pending[r].
  - Same register set and cleared on the same edge: set wins, so the bit stays 1.
  - read_busy[k] = pending[read_reg[k]] AND NOT (BYPASS=1 AND regWrite=1 AND write_reg==read_reg[k], writable).
  - pend_set has no effect on read_busy until the following cycle.
- pend_cnt:
  - Registered; equals the population of the pending vector after each edge.
  - Updated incrementally: +1 on a set of a clear bit, -1 on a clear of a set bit, unchanged when both apply to different registers.
  - Never wraps; maximum is NUM_REGS-ZERO_REG.

Decomposition:
- Shared package: BYPASS/ZERO_REG mode constants, the clog2 function, and a bus-slice helper for flat port vectors.
- One sub-module, rf_read_port: one mux plus bypass merge plus busy logic, instantiated NUM_RD times by a generate loop.

Test Plan:
1. Reset, then read ports 0,1 = regs 1,2 -> read_data = 0, read_busy = 0, pend_cnt = 0.
2. Write reg 31 = 0x00003000 with be=4'hF, then edge; reg 30 with be=4'b0011, data 0xFFFFFFFF -> reg31 reads 0x00003000, reg30 reads 0x0000FFFF.
3. Write reg 0 = 0xFFFFFFFF with ZERO_REG=1 -> reg 0 reads 0. Same-cycle bypass read of reg 5 while writing 0xA5A5A5A5 -> read_data = 0xA5A5A5A5 before the edge.
4. pend_set reg 7; next cycle read reg 7 -> read_busy=1, pend_cnt=1. Write reg 7 -> busy=0 in that cycle (bypass), pend_cnt=0 after the edge.
5. pend_set reg 9 and regWrite reg 9 on the same edge -> pending stays 1, pend_cnt=1. Assert rst_n low mid-cycle -> all outputs 0 immediately.
6. Instance with NUM_RD=3, DATA_W=64, NUM_REGS=16, BYPASS=0: write reg 15 = 0x0123456789ABCDEF -> old value until the edge, new value on all three ports after it.
